// File: rtl/seq_feeder_pkg.sv
// seq_feeder_pkg: shared state encoding and pattern-width limits for seq_feeder
package seq_feeder_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;
  localparam int PW_MIN = 2;
  localparam int PW_MAX = 16;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector, history resets high so a held level never fires
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic rise
);
  logic start_q;
  logic start_d;
  always_comb start_d = start;
  always_ff @(posedge clk) start_q <= rst ? 1'b1 : start_d;
  always_comb rise = start & ~start_q;
endmodule

// File: rtl/seq_feeder.sv
// seq_feeder: latches a pattern, clears and feeds a detector MSB first, counts its z hits
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int PATTERN_W = 8,
  localparam int CW = $clog2(PATTERN_W + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 z_in,
  output logic                 w_out,
  output logic                 fsm_reset,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        hit_count,
  output logic [CW-1:0]        first_hit
);
  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [CW-1:0]        k_q, k_d, hit_q, hit_d, first_q, first_d;
  logic                 rise, count;

  rise_detect u_rise (.clk(clk), .rst(reset), .start(start), .rise(rise));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      k_q     <= '0;
      hit_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      k_q     <= k_d;
      hit_q   <= hit_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = (state_q == S_IDLE)  ? (rise ? S_CLEAR : S_IDLE) :
              (state_q == S_CLEAR) ? S_SHIFT :
              (state_q == S_SHIFT) ? ((k_q == CW'(PATTERN_W - 1)) ? S_DRAIN : S_SHIFT) :
              (state_q == S_DRAIN) ? S_DONE : S_IDLE;
  end

  // The pattern shifts left so its MSB is always the current bit; k reaches PATTERN_W in DRAIN,
  // which makes k the bits-consumed figure for both SHIFT and DRAIN hits.
  always_comb begin
    pat_d   = pat_q;
    k_d     = k_q;
    hit_d   = hit_q;
    first_d = first_q;
    count   = z_in && ((state_q == S_SHIFT && k_q != '0) || state_q == S_DRAIN);
    if (state_q == S_IDLE && rise) begin
      pat_d   = pattern;
      k_d     = '0;
      hit_d   = '0;
      first_d = '0;
    end
    if (state_q == S_CLEAR) k_d = '0;
    if (state_q == S_SHIFT) begin
      pat_d = pat_q << 1;
      k_d   = k_q + CW'(1);
    end
    if (count) begin
      hit_d   = (hit_q == CW'(PATTERN_W)) ? hit_q : hit_q + CW'(1);
      first_d = (first_q == '0) ? k_q : first_q;
    end
  end

  always_comb begin
    w_out     = (state_q == S_SHIFT) && pat_q[PATTERN_W-1];
    busy      = state_q inside {S_CLEAR, S_SHIFT, S_DRAIN};
    done      = state_q == S_DONE;
    fsm_reset = reset || state_q == S_CLEAR;
    hit_count = hit_q;
    first_hit = first_q;
  end
endmodule

// File: tb/tb_seq_feeder.sv
// tb_seq_feeder: table-driven reset/feed vectors plus directed multi-cycle run checks
module tb_seq_feeder;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic       clk = 1'b0;
  logic       reset, start, z_in;
  logic [7:0] pattern;
  logic       w_out, fsm_reset, busy, done;
  logic [3:0] hit_count, first_hit;
  int         vectors = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  seq_feeder #(.PATTERN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .z_in(z_in),
    .w_out(w_out), .fsm_reset(fsm_reset), .busy(busy), .done(done),
    .hit_count(hit_count), .first_hit(first_hit)
  );

  typedef struct {
    logic       r, s, z;
    logic [7:0] p;
    logic       w, fr, b, d;
    logic [3:0] hit, first;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic z, input logic [7:0] p);
    @(negedge clk);
    reset   = r;
    start   = s;
    z_in    = z;
    pattern = p;
    #1;
  endtask

  // One run with the start edge sampled at cycle 0; zm picks the z_in profile.
  task automatic run(input string n, input logic [7:0] p, input int zm, input bit busy_test,
                     input logic [3:0] eh, input logic [3:0] ef);
    int         nd = 0;
    int         dc = -1;
    logic [7:0] wb = '0;
    logic       zv;
    for (int c = 0; c < 17; c++) begin
      zv = (zm == 1) ? 1'b1 : (zm == 2) ? (c == 10) : (zm == 3) ? (c == 2 || c == 4 || c == 7) : 1'b0;
      drive(L, (c == 0) || (busy_test && c == 5), zv, (busy_test && c >= 3) ? 8'h4D : p);
      if (c == 1) chk({n, ".clear_rst"}, fsm_reset, 1);
      if (c >= 2 && c <= 9) wb[9-c] = w_out;
      if (done === 1'b1) begin
        nd++;
        dc = c;
      end
    end
    chk({n, ".w_bits"}, wb, p);
    chk({n, ".done_cnt"}, nd, 1);
    chk({n, ".done_cyc"}, dc, 11);
    chk({n, ".hit"}, hit_count, eh);
    chk({n, ".first"}, first_hit, ef);
  endtask

  initial begin
    logic [7:0] wp;
    int         nd;
    wp = 8'hB2;
    reset = 1'b1;
    start = 1'b1;
    z_in = 1'b0;
    pattern = 8'hB2;
    tbl[0]  = '{H, H, L, 8'hB2, L, H, L, L, 4'd0, 4'd0};
    tbl[1]  = '{H, H, L, 8'hB2, L, H, L, L, 4'd0, 4'd0};
    tbl[2]  = '{L, H, L, 8'hB2, L, L, L, L, 4'd0, 4'd0};
    tbl[3]  = '{L, H, L, 8'hB2, L, L, L, L, 4'd0, 4'd0};
    tbl[4]  = '{L, L, L, 8'hB2, L, L, L, L, 4'd0, 4'd0};
    tbl[5]  = '{L, H, L, 8'hB2, L, L, L, L, 4'd0, 4'd0};
    tbl[6]  = '{L, L, L, 8'h00, L, H, H, L, 4'd0, 4'd0};
    for (int j = 0; j < 8; j++) tbl[7+j] = '{L, L, L, 8'h00, wp[7-j], L, H, L, 4'd0, 4'd0};
    tbl[15] = '{L, L, L, 8'h00, L, L, H, L, 4'd0, 4'd0};
    tbl[16] = '{L, L, L, 8'h00, L, L, L, H, 4'd0, 4'd0};
    tbl[17] = '{L, L, L, 8'h00, L, L, L, L, 4'd0, 4'd0};
    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].z, tbl[i].p);
      chk($sformatf("v%0d.w_out", i), w_out, tbl[i].w);
      chk($sformatf("v%0d.fsm_reset", i), fsm_reset, tbl[i].fr);
      chk($sformatf("v%0d.busy", i), busy, tbl[i].b);
      chk($sformatf("v%0d.done", i), done, tbl[i].d);
      chk($sformatf("v%0d.hit", i), hit_count, tbl[i].hit);
      chk($sformatf("v%0d.first", i), first_hit, tbl[i].first);
    end
    run("all_hits", 8'hB2, 1, 1'b0, 4'd8, 4'd1);
    run("drain_hit", 8'hB2, 2, 1'b0, 4'd1, 4'd8);
    run("busy_ignore", 8'hB2, 0, 1'b1, 4'd0, 4'd0);
    run("mid_hits", 8'h69, 3, 1'b0, 4'd2, 4'd2);
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      drive(c == 6, c == 0, H, 8'hB2);
      if (done === 1'b1) nd++;
      if (c == 6) begin
        chk("mid_rst.fsm_reset", fsm_reset, 1);
        chk("mid_rst.partial_hit", hit_count, 3);
      end
      if (c == 7) begin
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.hit", hit_count, 0);
        chk("mid_rst.first", first_hit, 0);
        chk("mid_rst.w_out", w_out, 0);
        chk("mid_rst.fsm_reset_off", fsm_reset, 0);
      end
    end
    chk("mid_rst.no_done", nd, 0);
    run("after_rst", 8'h5A, 2, 1'b0, 4'd1, 4'd8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
